// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared definitions for the digit-serial adder/subtractor:
//                FSM state encoding, default geometry and a helper that sizes
//                the step counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Explicit encodings keep state values stable across tools and netlists.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIGIT = 1;

    // Step counter width: $clog2(steps), but never narrower than one bit so a
    // single-step configuration still has a legal counter vector.
    function automatic int ctr_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_fa_cell
//  Description : 1-bit full adder cell; one link of the ripple chain used by
//                serial_adder.
//  Ports       : a, b  - operand bits
//                ci    - carry in
//                s     - sum bit
//                co    - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Multi-cycle adder/subtractor. Adds DIGIT bits per clock,
//                least-significant digit first, through a ripple chain of
//                DIGIT full-adder cells. Operands arrive on a valid/ready
//                input handshake; the result leaves on a valid/ready output
//                handshake. One operation takes WIDTH/DIGIT RUN cycles.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                in_valid/in_ready     - operand handshake
//                a, b, cin, sub        - operands, carry-in, subtract select
//                out_valid/out_ready   - result handshake
//                sum, cout, ovf        - result, carry out, signed overflow
//                busy                  - high while in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int             STEPS = WIDTH / DIGIT;
    localparam int             CW    = ctr_width(STEPS);
    localparam logic [CW-1:0]  LAST  = CW'(STEPS - 1);

    // ------------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------------
    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_param_check
            $error("serial_adder: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
                   WIDTH, DIGIT);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    step;

    logic [DIGIT:0]   chain_c;
    logic [DIGIT-1:0] chain_s;
    logic [WIDTH-1:0] sum_next;
    logic             accept;
    logic             last_step;

    // ------------------------------------------------------------------------
    // Ripple chain over the current low digit of the operand shift registers
    // ------------------------------------------------------------------------
    assign chain_c[0] = carry;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_chain
            serial_adder_fa_cell u_fa (
                .a  (a_sh[i]),
                .b  (b_sh[i]),
                .ci (chain_c[i]),
                .s  (chain_s[i]),
                .co (chain_c[i+1])
            );
        end
    endgenerate

    // New digit enters the sum register at the MSB end, so after STEPS
    // shifts the first (least significant) digit lands in bits [DIGIT-1:0].
    generate
        if (DIGIT == WIDTH) begin : g_sum_full
            assign sum_next = chain_s;
        end else begin : g_sum_shift
            assign sum_next = {chain_s, sum_sh[WIDTH-1:DIGIT]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // Accepting while DONE requires the current result to be consumed on the
    // same edge, which gives back-to-back operations with no idle bubble.
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_step = (step == LAST);
    assign sum       = sum_sh;

    // ------------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum_sh    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            step      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Operand load is handled by the accept path below.
                end

                ST_RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    carry  <= chain_c[DIGIT];
                    sum_sh <= sum_next;
                    step   <= step + 1'b1;
                    if (last_step) begin
                        // On the final digit the top cell is bit WIDTH-1, so
                        // its carry-in is the carry into the MSB.
                        cout      <= chain_c[DIGIT];
                        ovf       <= chain_c[DIGIT] ^ chain_c[DIGIT-1];
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase

            // Placed after the case so a same-edge accept in DONE overrides
            // the return to IDLE.
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b ^ {WIDTH{sub}};
                carry <= sub | cin;
                step  <= '0;
                state <= ST_RUN;
                busy  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
